ps2_scan_ctrl: RTL
==================

Name: ps2_scan_ctrl

Overview:
- Sequencer placed after the PS/2 frame receiver.
- Consumes validated scan-code bytes and parses the set-2 prefix sequences (E0 = extended, F0 = break).
- Emits one key event per completed sequence into a small show-ahead FIFO with a valid/ready consumer handshake.
- Tracks the most recently held key and a press counter, and aborts stalled prefix sequences via a watchdog.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes of one sequence before abort.
- CNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset, synchronous, active-low.
- rx_valid  input  1  single-cycle strobe: rx_data holds a good received byte.
- rx_data  input  8  received scan-code byte.
- rx_err  input  1  single-cycle strobe: frame error (start/stop/parity) on the last frame.
- ev_valid  output  1  FIFO non-empty; head event present on ev_*.
- ev_ready  input  1  consumer accepts head event when ev_valid=1.
- ev_code  output  8  head event scan code.
- ev_ext  output  1  head event carried E0 prefix.
- ev_break  output  1  head event is a release.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries stored.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- held_valid  output  1  a key is currently held.
- held_code  output  8  code of the held key.
- held_ext  output  1  held key is extended.
- press_count  output  CNT_W  number of make events accepted into the FIFO; wraps.
- seq_timeout  output  1  single-cycle pulse: a sequence was aborted by the watchdog.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, watchdog cleared.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions happen only on rx_valid.
  - Byte E0 from any state -> GOT_E0 (restarts the sequence).
  - Byte F0: IDLE -> GOT_F0; GOT_E0 -> GOT_E0F0; GOT_F0 and GOT_E0F0 hold their state.
  - Any other byte X -> push event {code=X, ext, brk} and return to IDLE.
    - ext=1 in GOT_E0 and GOT_E0F0, else 0.
    - brk=1 in GOT_F0 and GOT_E0F0, else 0.
- rx_err: FSM -> IDLE, nothing pushed. If rx_err and rx_valid occur in the same cycle, rx_err wins and the byte is ignored.
- Watchdog:
  - Counts clk cycles while the FSM is not IDLE; cleared on every rx_valid and whenever the FSM is IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 with no byte arriving: FSM -> IDLE and seq_timeout pulses for 1 cycle.
  - If a byte arrives in that same cycle, the byte is processed and no timeout occurs.
- Event latency: an event pushed on rx_valid in cycle N is visible on ev_valid/ev_* in cycle N+1.
- FIFO:
  - Show-ahead; a pop occurs when ev_valid && ev_ready.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set; overflow clears only on reset.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Held tracking and press counting apply only to events accepted into the FIFO:
  - Make: held_valid=1, held_code/held_ext updated; press_count +1, wrapping at 2^CNT_W.
  - Break matching held_code and held_ext: held_valid=0.
  - Break not matching: held_* unchanged.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined: a make event equal to the current held key (held_valid=1, same code and ext) is suppressed. Nothing is pushed, press_count is unchanged and overflow is not affected, so typematic repeats are removed.
- Undefined: every make event is pushed as described above.

Test Plan:
- Bytes 1C, F0, 1C -> events {1C,ext0,brk0} then {1C,ext0,brk1}; press_count=1; held_valid 1 then 0.
- Bytes E0, 75, E0, F0, 75 -> events {75,ext1,brk0} then {75,ext1,brk1}; ev_valid rises 1 cycle after the 75 strobe.
- ev_ready=0 and FIFO_DEPTH+1 make codes sent -> fifo_count=FIFO_DEPTH, overflow=1, press_count=FIFO_DEPTH. Then drain -> codes pop in arrival order.
- Byte E0, then no byte for TIMEOUT_CYCLES -> seq_timeout pulses once. A following 1C yields {1C,ext0,brk0}.
- F0, then rx_err, then 1C -> single event {1C,ext0,brk0}. Also: rx_err together with rx_valid -> the byte is ignored.
- Bytes 1C, 1C, 1C with PS2_TYPEMATIC_FILTER_EN defined -> 1 event, press_count=1. With the macro undefined -> 3 events, press_count=3.

Source files
------------

// File: rtl/ps2_scan_ctrl.sv
// PS/2 set-2 scan-code sequencer: parses E0/F0 prefixes into key events and
// queues them in a show-ahead FIFO. Define PS2_TYPEMATIC_FILTER_EN to drop typematic repeats.
module ps2_scan_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_err,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          held_valid,
  output logic [7:0]                    held_code,
  output logic                          held_ext,
  output logic [CNT_W-1:0]              press_count,
  output logic                          seq_timeout,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    WD_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    WD_ONE   = 1;
  localparam logic [AW-1:0]    PTR_ONE  = 1;
  localparam logic [AW:0]      CNT_ONE  = 1;
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PRS_ONE  = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_E0   = 2'd1;
  localparam logic [1:0] S_F0   = 2'd2;
  localparam logic [1:0] S_E0F0 = 2'd3;

  logic [1:0]       r_state, w_state_nxt;
  logic [TW-1:0]    r_wd;
  logic             r_seq_timeout;
  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_held_valid, r_held_ext;
  logic [7:0]       r_held_code;
  logic [CNT_W-1:0] r_press;

  logic w_byte, w_is_e0, w_is_f0, w_code_byte, w_ext, w_brk;
  logic w_timeout, w_match_held, w_suppress, w_push, w_pop, w_full, w_accept, w_drop;
  logic [9:0] w_entry, w_head;

  assign w_byte      = rx_valid && !rx_err;
  assign w_is_e0     = (rx_data == 8'hE0);
  assign w_is_f0     = (rx_data == 8'hF0);
  assign w_code_byte = w_byte && !w_is_e0 && !w_is_f0;
  assign w_ext       = (r_state == S_E0) || (r_state == S_E0F0);
  assign w_brk       = (r_state == S_F0) || (r_state == S_E0F0);
  assign w_timeout   = (r_state != S_IDLE) && !rx_valid && !rx_err && (r_wd == WD_LAST);
  assign w_entry     = {w_ext, w_brk, rx_data};

  assign w_match_held = r_held_valid && (rx_data == r_held_code) && (w_ext == r_held_ext);
`ifdef PS2_TYPEMATIC_FILTER_EN
  assign w_suppress = !w_brk && w_match_held;
`else
  assign w_suppress = 1'b0;
`endif

  // Consumer handshake: the head entry is transferred on any cycle where
  // ev_valid && ev_ready; ev_valid never depends on ev_ready.
  assign w_push   = w_code_byte && !w_suppress;
  assign w_pop    = (r_count != '0) && ev_ready;
  assign w_full   = (r_count == CNT_FULL);
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    if (rx_err) begin
      w_state_nxt = S_IDLE;
    end else if (rx_valid) begin
      if (w_is_e0) begin
        w_state_nxt = S_E0;
      end else if (w_is_f0) begin
        if (r_state == S_IDLE)    w_state_nxt = S_F0;
        else if (r_state == S_E0) w_state_nxt = S_E0F0;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_wd          <= '0;
      r_seq_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_seq_timeout <= w_timeout;
      if (rx_valid || (r_state == S_IDLE) || w_timeout) r_wd <= '0;
      else                                               r_wd <= r_wd + WD_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr <= r_wr + PTR_ONE;
      if (w_pop)    r_rd <= r_rd + PTR_ONE;
      if (w_accept && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_accept && w_pop) r_count <= r_count - CNT_ONE;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Held key follows only events that actually entered the FIFO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_held_valid <= 1'b0;
      r_held_code  <= 8'h00;
      r_held_ext   <= 1'b0;
      r_press      <= '0;
    end else if (w_accept) begin
      if (!w_brk) begin
        r_held_valid <= 1'b1;
        r_held_code  <= rx_data;
        r_held_ext   <= w_ext;
        r_press      <= r_press + PRS_ONE;
      end else if (w_match_held) begin
        r_held_valid <= 1'b0;
      end
    end
  end

  assign w_head      = r_mem[r_rd];
  assign ev_valid    = (r_count != '0);
  assign ev_code     = ev_valid ? w_head[7:0] : 8'h00;
  assign ev_break    = ev_valid && w_head[8];
  assign ev_ext      = ev_valid && w_head[9];
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;
  assign held_valid  = r_held_valid;
  assign held_code   = r_held_code;
  assign held_ext    = r_held_ext;
  assign press_count = r_press;
  assign seq_timeout = r_seq_timeout;
  assign dbg_state   = r_state;

endmodule
